// File: rtl/cordic_core.sv
// Rotation-mode CORDIC producing cos/sin of a signed Q2.30 angle in 32 micro-rotations.
// Define CORDIC_UNROLLED_EN to replace the iterative datapath with a single-cycle unrolled one.
module cordic_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] theta,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out,
    output logic        done
);

    typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    localparam logic [31:0] K_INV = 32'h26DD3B6A;

    state_t state, state_next;

    function automatic logic [31:0] atan_tab(input logic [4:0] idx);
        logic [31:0] a;
        case (idx)
            5'd0:  a = 32'h3243F6A8;
            5'd1:  a = 32'h1DAC6705;
            5'd2:  a = 32'h0FADBAFD;
            5'd3:  a = 32'h07F56EA7;
            5'd4:  a = 32'h03FEAB77;
            5'd5:  a = 32'h01FFD55C;
            5'd6:  a = 32'h00FFFAAB;
            5'd7:  a = 32'h007FFF55;
            5'd8:  a = 32'h003FFFEB;
            5'd9:  a = 32'h001FFFFD;
            5'd10: a = 32'h00100000;
            5'd11: a = 32'h00080000;
            5'd12: a = 32'h00040000;
            5'd13: a = 32'h00020000;
            5'd14: a = 32'h00010000;
            5'd15: a = 32'h00008000;
            5'd16: a = 32'h00004000;
            5'd17: a = 32'h00002000;
            5'd18: a = 32'h00001000;
            5'd19: a = 32'h00000800;
            5'd20: a = 32'h00000400;
            5'd21: a = 32'h00000200;
            5'd22: a = 32'h00000100;
            5'd23: a = 32'h00000080;
            5'd24: a = 32'h00000040;
            5'd25: a = 32'h00000020;
            5'd26: a = 32'h00000010;
            5'd27: a = 32'h00000008;
            5'd28: a = 32'h00000004;
            5'd29: a = 32'h00000002;
            5'd30: a = 32'h00000001;
            default: a = 32'h00000000;
        endcase
        return a;
    endfunction

    // Direction comes from the sign of the residual angle; z >= 0 rotates positively.
    function automatic vec_t micro_rot(input vec_t v, input logic [4:0] idx);
        vec_t        r;
        logic [31:0] xs;
        logic [31:0] ys;
        xs = $signed(v.x) >>> idx;
        ys = $signed(v.y) >>> idx;
        if (!v.z[31]) begin
            r.x = v.x - ys;
            r.y = v.y + xs;
            r.z = v.z - atan_tab(idx);
        end else begin
            r.x = v.x + ys;
            r.y = v.y - xs;
            r.z = v.z + atan_tab(idx);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

`ifdef CORDIC_UNROLLED_EN

    vec_t unr;

    always_comb begin
        unr = {K_INV, 32'd0, theta};
        for (int unsigned k = 0; k < 32; k++) begin
            unr = micro_rot(unr, 5'(k));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_out <= '0;
            sin_out <= '0;
            done    <= 1'b0;
        end else if (state == LOAD) begin
            cos_out <= unr.x;
            sin_out <= unr.y;
            done    <= 1'b1;
        end
    end

`else

    vec_t       cur;
    vec_t       nxt;
    logic [4:0] iter;

    always_comb begin
        nxt = micro_rot(cur, iter);
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = ITER;
            ITER:    if (iter == 5'd31) state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= '0;
            iter    <= '0;
            cos_out <= '0;
            sin_out <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cur  <= {K_INV, 32'd0, theta};
                    iter <= '0;
                end
                ITER: begin
                    cur  <= nxt;
                    iter <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        cos_out <= nxt.x;
                        sin_out <= nxt.y;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_cordic_core.sv
// Scoreboard bench for cordic_core: expected cos/sin queued at stimulus, compared when done rises.
module tb_cordic_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] theta = '0;
    logic [31:0] cos_out, sin_out;
    logic        done;

`ifdef CORDIC_UNROLLED_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 33;
`endif
    localparam int TOL = 256;

    typedef struct {
        string       tag;
        logic [31:0] c;
        logic [31:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cordic_core dut (
        .clk    (clk),
        .rst    (rst),
        .theta  (theta),
        .cos_out(cos_out),
        .sin_out(sin_out),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        longint d;
        d = longint'($signed(got)) - longint'($signed(exp));
        if (d < 0) d = -d;
        n_tests++;
        if (d > longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic logic [31:0] q30(input real r);
        real v;
        v = r * 1073741824.0;
        v = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return 32'($rtoi(v));
    endfunction

    function automatic real ang(input logic [31:0] th);
        return $itor($signed(th)) / 1073741824.0;
    endfunction

    // Releases reset, scrambles theta after the LOAD edge, returns the edge where done appears (-1 on timeout).
    task automatic release_and_wait(output int edge_no);
        edge_no = -1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= LAT + 8; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) theta = theta ^ 32'h5A5A5A5A;
            if (done) begin
                edge_no = e;
                return;
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] th, input logic [31:0] ec, input logic [31:0] es);
        int          ed;
        exp_t        e;
        logic [31:0] hc, hs;
        rst   = 1'b1;
        theta = th;
        sb.push_back('{tag, ec, es});
        @(negedge clk);
        @(negedge clk);
        release_and_wait(ed);
        check({tag, "_latency"}, 32'(ed), 32'(LAT), 0);
        e = sb.pop_front();
        check({e.tag, "_cos"}, cos_out, e.c, TOL);
        check({e.tag, "_sin"}, sin_out, e.s, TOL);
        hc = cos_out;
        hs = sin_out;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_cos"}, cos_out, hc, 0);
        check({tag, "_hold_done"}, 32'(done), 32'd1, 0);
    endtask

    initial begin
        int          ed;
        logic [31:0] th;
        exp_t        e;

        #1;
        check("reset_cos", cos_out, 32'd0, 0);
        check("reset_sin", sin_out, 32'd0, 0);
        check("reset_done", 32'(done), 32'd0, 0);

        run_one("deg40",  32'h2CAE3080, 32'h3106DF46, 32'h29236EA4);
        run_one("degm40", 32'hD351CF80, 32'h3106DF46, 32'hD6DC915C);
        run_one("pi4",    32'h3243F6A8, 32'h2D413CCD, 32'h2D413CCD);
        run_one("zero",   32'h00000000, 32'h40000000, 32'h00000000);
        run_one("pi2",    32'h6487ED51, q30($cos(ang(32'h6487ED51))), q30($sin(ang(32'h6487ED51))));
        run_one("mpi2",   32'h9B7812AF, q30($cos(ang(32'h9B7812AF))), q30($sin(ang(32'h9B7812AF))));
        for (int k = 0; k < 6; k++) begin
            th = 32'($urandom_range(32'h6487ED51, 0));
            if ($urandom_range(1, 0) == 1) th = -th;
            run_one($sformatf("rand%0d", k), th, q30($cos(ang(th))), q30($sin(ang(th))));
        end

        // Asynchronous reset from DONE clears outputs between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cos", cos_out, 32'd0, 0);
        check("async_rst_sin", sin_out, 32'd0, 0);
        check("async_rst_done", 32'(done), 32'd0, 0);

        // Reset pulse mid-computation, then a fresh run with theta changed after LOAD.
        theta = 32'h2CAE3080;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_done", 32'(done), 32'd0, 0);
        check("mid_rst_cos", cos_out, 32'd0, 0);
        theta = 32'h2CAE3080;
        sb.push_back('{"restart40", 32'h3106DF46, 32'h29236EA4});
        release_and_wait(ed);
        check("restart_latency", 32'(ed), 32'(LAT), 0);
        e = sb.pop_front();
        check({e.tag, "_cos"}, cos_out, e.c, TOL);
        check({e.tag, "_sin"}, sin_out, e.s, TOL);

        // Reset asserted across the final edge: done must stay low.
        rst = 1'b1;
        theta = 32'h3243F6A8;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("final_edge_rst_done", 32'(done), 32'd0, 0);
        check("final_edge_rst_sin", sin_out, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_core.md
# cordic_core

Fixed-point CORDIC engine in rotation mode that computes the cosine and sine of a signed angle. It runs 32 micro-rotations in sequence, one per clock, and raises a sticky `done` flag when the results are valid. It is a leaf arithmetic block for datapaths that need a one-shot sin/cos. A compile-time option swaps the iterative datapath for a fully unrolled single-cycle one.

## Interface
- No parameters. Width (32), iteration count (32) and number format (signed Q2.30) are fixed.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- theta  input  32  angle in radians, signed Q2.30 (1.0 = 0x40000000).
- cos_out  output  32  cos(theta), signed Q2.30, registered.
- sin_out  output  32  sin(theta), signed Q2.30, registered.
- done  output  1  high when cos_out and sin_out are valid; sticky until reset.

## Operation
- States: LOAD, ITER, DONE.
- While rst is high:
  - all registers clear asynchronously;
  - cos_out = 0, sin_out = 0, done = 0;
  - iteration counter = 0, state = LOAD.
- LOAD, on the first rising edge with rst low:
  - x = K = 0x26DD3B6A (0.607252935, the inverse CORDIC gain);
  - y = 0;
  - z = theta;
  - go to ITER with i = 0.
- ITER, on each edge for i = 0..31:
  - d = +1 if z ≥ 0, otherwise −1;
  - x' = x − d·(y >>> i);
  - y' = y + d·(x >>> i);
  - z' = z − d·atan_tab[i].
- Shifts are arithmetic; add/subtract are 32-bit two's complement with no saturation.
- atan_tab[i] = round(atan(2^-i)·2^30).
  - Entry 0 is 0x3243F6A8.
  - Entries round to nearest; tail entries may be 0 or 1.
  - The table is a constant ROM of 32 entries.
- After iteration i = 31:
  - cos_out ← x', sin_out ← y';
  - done ← 1;
  - state → DONE.
- DONE: outputs and done hold. A new computation only starts after another reset.
- theta is sampled only in LOAD. Changes after LOAD are ignored.
- Valid input range is |theta| ≤ π/2 (0x6487ED51). No quadrant folding is done.
  - Outside that range the outputs are deterministic but unspecified.
  - Callers must pre-reduce the angle.
- Accuracy: |error| ≤ 256 LSB on each output over the valid range.

## Timing
- Edge numbering counts rising edges after rst deasserts, starting at 1.
- Edge 1: LOAD. Edges 2–33: iterations 0–31.
- Edge 33: cos_out, sin_out and done update together. done is first visible after edge 33.
- Latency from reset release to done is 33 cycles.
- Reset mid-operation (any state): outputs and done clear immediately, with no clock needed. The sequence restarts at LOAD after release.
- Asserting rst in the same cycle as the final iteration edge: reset wins and done stays 0.

## Configuration
- `CORDIC_UNROLLED_EN` defined:
  - the 32 stages are instantiated combinationally with the same equations and table;
  - edge 1 captures the final x and y of the sampled theta into cos_out and sin_out, with done = 1;
  - latency is 1 cycle; the other states collapse.
- Not defined: the iterative 33-cycle datapath above.
- Both builds produce bit-identical results for the same theta.

## Test plan
- theta = 0x2CAE3080 (40°), reset held 2 cycles then released:
  - done rises after edge 33;
  - cos_out ≈ 0x3106DF46, sin_out ≈ 0x29236EA4, each within ±256 LSB.
- theta = 0xD351CF80 (−40°): cos_out ≈ 0x3106DF46, sin_out ≈ 0xD6DC915C.
- theta = 0x3243F6A8 (π/4): cos_out ≈ sin_out ≈ 0x2D413CCD.
- theta = 0: cos_out ≈ 0x40000000, sin_out ≈ 0.
- Reset pulse at cycle 15:
  - outputs and done drop to 0 without a clock edge;
  - a fresh 33-cycle computation follows;
  - theta changed after LOAD has no effect on the result.
- Build with `CORDIC_UNROLLED_EN`, rerun the 40° case: done after edge 1, and the result equals the iterative build bit for bit.
